// File: rtl/mem_arbiter_pkg.sv
// Shared defaults, state encodings and grant helper for the main-memory arbiter.
// The parameter defaults of mem_arbiter and mem_array come from here.
package mem_arbiter_pkg;

  localparam int MEM_LATENCY = 5;
  localparam int MEM_LINE_W  = 128;
  localparam int MEM_ADDR_W  = 32;
  localparam int MEM_LINES   = 1024;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

  // On a tie the side that was not served last wins.
  function automatic gnt_t pick_grant(input logic req_i, input logic req_d, input gnt_t last);
    if (req_i && req_d) return (last == GNT_I) ? GNT_D : GNT_I;
    else if (req_d)     return GNT_D;
    else                return GNT_I;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port line storage with a registered read port; contents are not reset.
module mem_array
  import mem_arbiter_pkg::*;
#(
  parameter int LINES  = MEM_LINES,
  parameter int LINE_W = MEM_LINE_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(LINES)-1:0] idx,
  input  logic [LINE_W-1:0]        wdata,
  output logic [LINE_W-1:0]        rdata
);

  logic [LINE_W-1:0] mem [LINES];

  // NOTE: storage arrays get no reset; resetting them would turn the RAM into flops.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    rdata <= mem[idx];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between I- and D-cache miss paths in front of a fixed-latency
// main memory; one access in flight, one-cycle ack per access.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LATENCY = MEM_LATENCY,
  parameter int LINE_W  = MEM_LINE_W,
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int LINES   = MEM_LINES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [LINE_W-1:0] d_rdata
);

  localparam int IDX_W = $clog2(LINES);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  gnt_t              gnt_q, gnt_d, last_q;
  logic              we_q, accept, access;
  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] wdata_q, arr_rdata, i_rdata_q, d_rdata_q;

  // Offset bits and bits above the index are dropped, so addresses wrap modulo LINES.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[3:0], i_addr[ADDR_W-1:IDX_W+4],
                              d_addr[3:0], d_addr[ADDR_W-1:IDX_W+4]};

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    accept  = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (i_req || d_req) begin
          gnt_d   = pick_grant(i_req, d_req, last_q);
          cnt_d   = CNT_W'(LATENCY - 1);
          accept  = 1'b1;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             state_d = ARB_RESP;
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  assign access = (state_q == ARB_BUSY) && (cnt_q == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ARB_IDLE;
      cnt_q     <= '0;
      gnt_q     <= GNT_I;
      last_q    <= GNT_I;
      we_q      <= 1'b0;
      idx_q     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        gnt_q <= gnt_d;
        we_q  <= (gnt_d == GNT_D) && d_we;
        idx_q <= (gnt_d == GNT_D) ? d_addr[IDX_W+3:4] : i_addr[IDX_W+3:4];
      end
      if (state_q == ARB_RESP) begin
        last_q <= gnt_q;
        if (!we_q) begin
          if (gnt_q == GNT_I) i_rdata_q <= arr_rdata;
          else                d_rdata_q <= arr_rdata;
        end
      end
    end
  end

  // Write data only matters once the write is performed; it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) wdata_q <= d_wdata;
  end

  mem_array #(.LINES(LINES), .LINE_W(LINE_W)) u_array (
    .clk   (clk),
    .we    (access && we_q),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  // In RESP the array register already holds the line; afterwards the side register keeps it.
  assign i_ack   = (state_q == ARB_RESP) && (gnt_q == GNT_I);
  assign d_ack   = (state_q == ARB_RESP) && (gnt_q == GNT_D);
  assign i_rdata = i_ack ? arr_rdata : i_rdata_q;
  assign d_rdata = (d_ack && !we_q) ? arr_rdata : d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected acks are queued when requests are driven
// and compared by a monitor when the DUT acknowledges.
module tb_mem_arbiter;

  localparam int LAT = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0]  i_addr = '0, d_addr = '0;
  logic [127:0] d_wdata = '0;
  logic         i_ack, d_ack;
  logic [127:0] i_rdata, d_rdata;

  logic         i_req1 = 1'b0;
  logic [31:0]  i_addr1 = '0;
  logic         i_ack1, d_ack1;
  logic [127:0] i_rdata1, d_rdata1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_i_cyc = 0, last_d_cyc = 0;

  typedef struct {
    logic         side;
    logic [127:0] data;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] model_mem[int];
  logic [127:0] exp_i = '0, exp_d = '0;

  mem_arbiter #(.LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata)
  );

  mem_arbiter #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .i_req(i_req1), .i_addr(i_addr1), .i_ack(i_ack1), .i_rdata(i_rdata1),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(128'h0),
    .d_ack(d_ack1), .d_rdata(d_rdata1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pre_line(input int idx);
    logic [15:0] v;
    v = idx[15:0];
    return {8{v}};
  endfunction

  function automatic logic [127:0] model_line(input int idx);
    if (model_mem.exists(idx)) return model_mem[idx];
    return pre_line(idx);
  endfunction

  // Queue the expected ack in the order the arbiter should serve it.
  task automatic push_exp(input logic side, input logic we, input logic [31:0] addr,
                          input logic [127:0] wdata);
    exp_t e;
    int   idx;
    idx    = int'(addr[13:4]);
    e.side = side;
    if (we) begin
      model_mem[idx] = wdata;
      e.data = exp_d;
    end else begin
      e.data = model_line(idx);
      if (side) exp_d = e.data;
      else      exp_i = e.data;
    end
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (i_ack || d_ack) begin
      exp_t e;
      if (i_ack && d_ack) check("both_ack", 1'b1, 1'b0);
      if (i_ack) last_i_cyc = cyc;
      if (d_ack) last_d_cyc = cyc;
      if (sb.size() == 0) begin
        check("sb_underflow", 1'b0, 1'b1);
      end else begin
        e = sb.pop_front();
        check("ack_side", d_ack, e.side);
        if (e.side) check("d_rdata", d_rdata, e.data);
        else        check("i_rdata", i_rdata, e.data);
      end
    end
  end

  // Called on a negedge; returns on a negedge one cycle after the ack.
  task automatic access(input logic side, input logic we, input logic [31:0] addr,
                        input logic [127:0] wdata, input int exp_lat);
    int   n;
    logic got;
    if (side) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 64) begin
      @(negedge clk);
      n++;
      got = side ? d_ack : i_ack;
      if (exp_lat != 0) check("cross_ack", side ? i_ack : d_ack, 1'b0);
    end
    if (!got) check("ack_timeout", 1'b0, 1'b1);
    else if (exp_lat != 0) check("latency", 128'(n), 128'(exp_lat + 1));
    if (side) begin d_req = 1'b0; d_we = 1'b0; end
    else      i_req = 1'b0;
    @(negedge clk);
    check("ack_pulse", side ? d_ack : i_ack, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_i = '0;
    exp_d = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    logic got;
    for (int i = 0; i < 1024; i++) begin
      u_dut.u_array.mem[i]  = pre_line(i);
      u_dut1.u_array.mem[i] = pre_line(i);
    end
    repeat (3) @(negedge clk);
    check("rst_i_ack", i_ack, 1'b0);
    check("rst_d_ack", d_ack, 1'b0);
    check("rst_i_rdata", i_rdata, '0);
    check("rst_d_rdata", d_rdata, '0);
    rst = 1'b1;
    @(negedge clk);

    // Basic read latency.
    push_exp(1'b0, 1'b0, 32'h30, '0);
    access(1'b0, 1'b0, 32'h30, '0, LAT);

    // D read, write-back (d_rdata must hold), then read back.
    push_exp(1'b1, 1'b0, 32'h20, '0);
    access(1'b1, 1'b0, 32'h20, '0, LAT);
    push_exp(1'b1, 1'b1, 32'h40, {4{32'hDEADBEEF}});
    access(1'b1, 1'b1, 32'h40, {4{32'hDEADBEEF}}, LAT);
    push_exp(1'b1, 1'b0, 32'h40, '0);
    access(1'b1, 1'b0, 32'h40, '0, LAT);

    // Address wrap: 0x4030 aliases 0x30.
    push_exp(1'b0, 1'b0, 32'h4030, '0);
    access(1'b0, 1'b0, 32'h4030, '0, LAT);
    check("i_rdata_hold", i_rdata, pre_line(3));

    // Round robin: after reset D wins the tie, I follows with no idle grant.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      push_exp(1'b1, 1'b0, 32'h70, '0);
      push_exp(1'b0, 1'b0, 32'h80, '0);
      fork
        access(1'b1, 1'b0, 32'h70, '0, LAT);
        access(1'b0, 1'b0, 32'h80, '0, 0);
      join
      check("rr_gap", 128'(last_i_cyc - last_d_cyc), 128'(LAT + 2));
    end

    // Reset two cycles after a write is accepted: the write must never land.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h50; d_wdata = {4{32'h0BADF00D}};
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    d_req = 1'b0; d_we = 1'b0;
    #1;
    check("rst_mid_d_rdata", d_rdata, '0);
    check("rst_mid_i_rdata", i_rdata, '0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_mid_i_ack", i_ack, 1'b0);
      check("rst_mid_d_ack", d_ack, 1'b0);
    end
    rst = 1'b1;
    exp_i = '0;
    exp_d = '0;
    @(negedge clk);
    check("post_rst_d_rdata", d_rdata, '0);
    push_exp(1'b1, 1'b0, 32'h50, '0);
    access(1'b1, 1'b0, 32'h50, '0, LAT);

    // Minimum latency on the LATENCY=1 instance.
    i_req1 = 1'b1; i_addr1 = 32'h30;
    n = 0;
    got = 1'b0;
    while (!got && n < 16) begin
      @(negedge clk);
      n++;
      got = i_ack1;
      check("lat1_d_ack", d_ack1, 1'b0);
    end
    i_req1 = 1'b0;
    if (!got) check("lat1_timeout", 1'b0, 1'b1);
    check("lat1_latency", 128'(n), 128'd2);
    check("lat1_rdata", i_rdata1, pre_line(3));
    @(negedge clk);
    check("lat1_pulse", i_ack1, 1'b0);

    repeat (2) @(negedge clk);
    check("sb_drained", 128'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
